// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared widths, increment type and reference ratios for frac_clken_gen.
package clkgen_pkg;
    localparam int ACC_W_DEF = 32;
    typedef logic [ACC_W_DEF-1:0] inc_t;
    localparam inc_t INC_3M6 = 32'd114532461;
    localparam inc_t INC_3M58 = 32'd113881694;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/frac_clken_gen_if.sv
// frac_clken_gen_if: increment-write handshake (valid/ready, channel, increment).
interface frac_clken_gen_if import clkgen_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int ACC_W = ACC_W_DEF
);
    localparam int CW = ch_w(NUM_CH);
    logic cfg_valid;
    logic cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    modport master(output cfg_valid, cfg_ch, cfg_inc, input cfg_ready);
    modport slave(input cfg_valid, cfg_ch, cfg_inc, output cfg_ready);
endinterface

// File: rtl/frac_acc_ch.sv
// frac_acc_ch: one phase-accumulator channel with a pending increment applied on wrap.
// CLKGEN_PHASE_SYNC_EN adds sync_i, which zeroes the phase and applies any pending increment at once.
module frac_acc_ch import clkgen_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             clk_src,
    input  logic             rst_n,
`ifdef CLKGEN_PHASE_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             ce,
    output logic             clk_div,
    output logic             pend
);
    logic [ACC_W-1:0] acc, inc, pend_inc, acc_nxt;
    logic [ACC_W:0] sum;
    logic apply;
    assign sum = {1'b0, acc} + {1'b0, inc};
    // a stopped channel never wraps, so it takes its pending increment straight away
    assign apply = pend && (sum[ACC_W] || inc == '0);
    assign acc_nxt = (apply && pend_inc == '0) ? '0 : sum[ACC_W-1:0];
    always_ff @(posedge clk_src or negedge rst_n)
        if (!rst_n) begin
            acc <= '0;
            inc <= INC_RST;
            pend_inc <= '0;
            pend <= 1'b0;
            ce <= 1'b0;
            clk_div <= 1'b0;
        end
`ifdef CLKGEN_PHASE_SYNC_EN
        else if (sync_i) begin
            acc <= '0;
            ce <= 1'b0;
            clk_div <= 1'b0;
            if (pend) inc <= pend_inc;
            pend <= wr;
            if (wr) pend_inc <= wr_inc;
        end
`endif
        else begin
            acc <= acc_nxt;
            ce <= sum[ACC_W];
            clk_div <= acc_nxt[ACC_W-1];
            if (apply) begin
                inc <= pend_inc;
                pend <= 1'b0;
            end
            // writes are only accepted while nothing is pending, so they never collide with apply
            if (wr) begin
                pend_inc <= wr_inc;
                pend <= 1'b1;
            end
        end
endmodule

// File: rtl/frac_clken_gen.sv
// frac_clken_gen: multi-channel fractional clock-enable / divided-clock generator.
// Optional phase alignment input sync_i when CLKGEN_PHASE_SYNC_EN is defined.
module frac_clken_gen import clkgen_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int ACC_W = ACC_W_DEF,
    parameter logic [ACC_W-1:0] INC_RST = ACC_W'(INC_3M6)
) (
    input  logic              clk_src,
    input  logic              rst_n,
`ifdef CLKGEN_PHASE_SYNC_EN
    input  logic              sync_i,
`endif
    frac_clken_gen_if.slave   cfg,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_div,
    output logic              busy
);
    localparam int CW = ch_w(NUM_CH);
    logic [NUM_CH-1:0] pend, hit;
    assign busy = |pend;
    // an out-of-range channel hits nothing: ready stays high and the write is dropped
    assign cfg.cfg_ready = !(|(hit & pend));
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign hit[i] = cfg.cfg_ch == CW'(i);
        frac_acc_ch #(.ACC_W(ACC_W), .INC_RST(INC_RST)) u_ch (
            .clk_src(clk_src),
            .rst_n(rst_n),
`ifdef CLKGEN_PHASE_SYNC_EN
            .sync_i(sync_i),
`endif
            .wr(cfg.cfg_valid && hit[i] && !pend[i]),
            .wr_inc(cfg.cfg_inc),
            .ce(ce[i]),
            .clk_div(clk_div[i]),
            .pend(pend[i])
        );
    end
endmodule

// File: doc/frac_clken_gen.md
# frac_clken_gen

Multi-channel fractional clock-enable generator that replaces single-ratio fixed clock dividers in the video/audio timing path. Each channel runs an ACC_W-bit phase accumulator clocked by `clk_src`, emitting a one-cycle clock-enable pulse on every accumulator wrap and a near-50% divided square wave from the accumulator MSB. Ratios are runtime-programmable per channel and switch glitch-free at the next wrap, so pixel and PSG clocks (e.g. 3.6 MHz from 135 MHz) are derived without long-term drift.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- ACC_W, 32, accumulator/increment width (8..32)
- INC_RST, 114532461, reset increment for all channels (3.6/135 × 2^32); 0 = channels start stopped
- clk_src  in  1  source clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  increment write request
- cfg_ready  out  1  write accepted when high with cfg_valid
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_inc  in  ACC_W  new phase increment
- ce  out  NUM_CH  per-channel one-cycle enable pulse
- clk_div  out  NUM_CH  per-channel divided square wave
- busy  out  1  any channel has a pending increment
- sync_i  in  1  phase-align strobe (only with CLKGEN_PHASE_SYNC_EN)

## Operation
- Per channel: registers acc[ACC_W-1:0], inc, pend_inc, pend (flag).
- Each cycle: {carry, acc} <= acc + inc (ACC_W+1-bit sum, carry discarded from acc).
- ce[i] <= carry; clk_div[i] <= MSB of new acc.
- Average frequency: f(clk_src) × inc / 2^ACC_W; period jitter ≤ 1 clk_src cycle.
- Config: cfg_ready = !pend[cfg_ch]. Handshake at edge with cfg_valid && cfg_ready: pend_inc <= cfg_inc, pend <= 1.
- Apply: at the edge where the channel's add produces carry, inc <= pend_inc, pend <= 0; that add still uses the old inc.
- Stopped channel (inc == 0): pending applied at the next edge, acc kept at 0.
- Writing inc = 0: applied at next wrap; acc cleared to 0 on that edge, ce/clk_div go low thereafter and stay low.
- Same-channel write while pending: stalled (cfg_ready low) until applied; a write on the apply edge is not accepted (cfg_ready derived from registered pend).
- Writes to other channels are independent; cfg_ch ≥ NUM_CH: cfg_ready = 1, write dropped.
- busy = |pend.

## Timing
- Reset (async assert, sync-released by the parent): acc = 0, inc = INC_RST, pend = 0, pend_inc = 0; ce = 0, clk_div = 0, busy = 0, cfg_ready = 1.
- ce/clk_div registered: carry in add of cycle n appears on ce in cycle n+1.
- First ce after reset with inc = 2^(ACC_W-k): cycle 2^k.
- Config acceptance to apply: ≤ ceil(2^ACC_W / inc_old) cycles; 1 cycle if stopped.
- Reset mid-pending: pending discarded, INC_RST restored.

## Configuration
- CLKGEN_PHASE_SYNC_EN defined: sync_i port exists; on edge with sync_i = 1, all acc <= 0, all pending increments applied immediately, pend cleared, ce <= 0 for that cycle; sync has priority over carry and over apply-on-wrap; a cfg write on the same edge is accepted and applied at the next wrap.
- Undefined: no sync_i port, no sync logic; channels free-run from reset phase.

## Structure
- Package clkgen_pkg: ACC_W default, inc_t typedef, constants INC_3M6 (114532461), INC_3M58 (NTSC colourburst ratio), channel index width function.
- Sub-module frac_acc_ch: one accumulator/pending/apply slice; top holds cfg decode, cfg_ready mux, busy reduce, and generate loop.

## Test plan
- NUM_CH=2, ACC_W=8, INC_RST=64 → ce[0]/ce[1] pulse every 4 cycles, first at cycle 4; clk_div 2 high/2 low.
- ch0 inc=64, write 32 mid-period → 64 continues until next ce, then ce every 8 cycles; cfg_ready for ch0 low until apply, busy high same interval.
- inc=3 (ACC_W=8) for 256×3 cycles → exactly 3 ce pulses per 256 cycles, spacing 85/85/86.
- Write inc=0 to ch1 → after next wrap ce[1]=0, clk_div[1]=0 permanently; then write 128 → ce every 2 cycles starting within 2 cycles.
- rst_n low while ch0 pending → all outputs 0, busy 0, inc back to INC_RST.
- CLKGEN_PHASE_SYNC_EN: ch0=64, ch1=32 free-running, pulse sync_i → both acc 0, next ce[0] 4 cycles and ce[1] 8 cycles later, coincident thereafter every 8.
